rtlola_verdict_collector: RTL and testbench
===========================================

// Module: rtlola_verdict_collector
// PURPOSE
//  Receive end of the monitor's output-stream interface. Samples output_0/output_1 and their
//  _aktv flags every clock and stamps each active cycle with a cycle timestamp. Buffers the
//  resulting records in a FIFO and drains them to a host/logger over a valid/ready handshake.
//  Sits between the topEntity monitor outputs and the trace/UART/DMA path.
// PARAMETERS
//  DATA_W  64  width of each signed output stream value
//  TS_W    32  width of the free-running cycle timestamp
//  DEPTH   16  FIFO depth in records; power of two, >= 2
// PORTS
//  clk            in   1            rising-edge clock
//  rst            in   1            asynchronous reset, active-high
//  en             in   1            global enable, same signal that drives the monitor
//  output_0       in   DATA_W       monitor stream 0 value (signed)
//  output_0_aktv  in   1            stream 0 produced a value this cycle
//  output_1       in   DATA_W       monitor stream 1 value (signed)
//  output_1_aktv  in   1            stream 1 produced a value this cycle
//  rec_valid      out  1            record available at head of FIFO
//  rec_ready      in   1            host accepts head record
//  rec_ts         out  TS_W         timestamp of head record
//  rec_mask       out  2            {aktv_1, aktv_0} of head record
//  rec_data_0     out  DATA_W       stream 0 value; 0 when rec_mask[0]=0
//  rec_data_1     out  DATA_W       stream 1 value; 0 when rec_mask[1]=0
//  overflow       out  1            sticky: at least one record was dropped
//  ovf_clr        in   1            one-cycle pulse; clears overflow and dropped_cnt
//  dropped_cnt    out  16           number of dropped records, saturating
// BEHAVIOUR
//  - Reset: ts=0, FIFO empty, rec_valid=0, rec_ts/rec_mask/rec_data_*=0, overflow=0, dropped_cnt=0.
//    Asserting reset mid-drain discards all buffered records immediately.
//  - Timestamp: ts increments by 1 on each clk edge with en=1, wraps 2^TS_W-1 -> 0.
//    ts holds while en=0. The first enabled cycle after reset carries ts=0.
//  - Capture: on an edge with en=1 and (aktv_0|aktv_1), push {ts, mask, masked data} using the
//    pre-increment ts. Inactive stream data is written as 0. No capture while en=0.
//  - Latency: a record pushed into an empty FIFO asserts rec_valid on the next cycle.
//    The FIFO is show-ahead: rec_* already present the head record.
//  - Handshake: pop occurs on an edge with rec_valid&rec_ready. rec_* stay stable while
//    rec_valid&!rec_ready. rec_ready while !rec_valid has no effect. Draining continues
//    while en=0.
//  - Full: fullness is judged on the pre-edge occupancy. Push with FIFO full and no pop is
//    dropped: overflow<=1, dropped_cnt+1, saturating at 0xFFFF. Push and pop together on a
//    full FIFO: both happen and occupancy stays DEPTH. Pointers wrap modulo DEPTH; the
//    occupancy counter is log2(DEPTH)+1 bits wide.
//  - ovf_clr coinciding with a drop: the drop wins, giving overflow=1 and dropped_cnt=1.
// CONFIGURATION
//  COLLECTOR_DROP_CNT_EN
//  - defined: dropped_cnt counts as specified above.
//  - undefined: dropped_cnt is tied to 0 and no counter is synthesised; overflow is still
//    implemented.
// TESTING
//  1 reset, en=1; at ts=999 drive aktv both, values 1/1 for 1 cycle -> one record
//    {ts=999, mask=2'b11, 1, 1}; rec_valid rises 1 cycle after the capture edge.
//  2 aktv_0 only, output_0=-5, output_1=77 -> rec_mask=2'b01, rec_data_0=-5, rec_data_1=0.
//  3 rec_ready=0, inject DEPTH+3 active cycles -> DEPTH records kept (oldest first),
//    overflow=1, dropped_cnt=3; ovf_clr pulse -> both return to 0.
//  4 FIFO full, push and rec_ready same cycle -> no drop, occupancy DEPTH, head advances by one.
//  5 en=0 for 10 cycles with aktv=1 -> no records, ts unchanged; buffered records still drain.
//  6 assert rst with 5 records queued -> rec_valid=0 asynchronously; after release the next
//    capture carries ts=0.

Source files
------------

// File: rtl/rtlola_verdict_collector_if.sv
// rtlola_verdict_collector_if: show-ahead record stream from the verdict collector to a host/logger.
interface rtlola_verdict_collector_if #(parameter int DATA_W = 64, parameter int TS_W = 32);
   logic                     rec_valid;
   logic                     rec_ready;
   logic        [TS_W-1:0]   rec_ts;
   logic        [1:0]        rec_mask;
   logic signed [DATA_W-1:0] rec_data_0;
   logic signed [DATA_W-1:0] rec_data_1;
   modport master (output rec_valid, rec_ts, rec_mask, rec_data_0, rec_data_1, input rec_ready);
   modport slave  (input rec_valid, rec_ts, rec_mask, rec_data_0, rec_data_1, output rec_ready);
endinterface

// File: rtl/rtlola_verdict_collector.sv
// rtlola_verdict_collector: timestamps active monitor output cycles and buffers them in a show-ahead FIFO.
// Define COLLECTOR_DROP_CNT_EN to build the saturating dropped-record counter; otherwise dropped_cnt is 0.
module rtlola_verdict_collector #(
   parameter int DATA_W = 64,
   parameter int TS_W   = 32,
   parameter int DEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic signed [DATA_W-1:0] output_0,
   input  logic                     output_0_aktv,
   input  logic signed [DATA_W-1:0] output_1,
   input  logic                     output_1_aktv,
   rtlola_verdict_collector_if.master rec,
   output logic                     overflow,
   input  logic                     ovf_clr,
   output logic [15:0]              dropped_cnt
);
   localparam int AW = $clog2(DEPTH);
   localparam int RW = TS_W + 2 + 2 * DATA_W;
   logic [RW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   cnt;
   logic [TS_W-1:0] ts;
   logic push_req, pop, full, push, drop;
   logic [RW-1:0] head;
   assign rec.rec_valid = cnt != '0;
   always_comb begin
      push_req = en & (output_0_aktv | output_1_aktv);
      full     = cnt == (AW+1)'(DEPTH);
      pop      = rec.rec_valid & rec.rec_ready;
      push     = push_req & (!full | pop);
      drop     = push_req & full & !pop;
      head     = rec.rec_valid ? mem[rd_ptr] : '0;
   end
   assign {rec.rec_ts, rec.rec_mask, rec.rec_data_1, rec.rec_data_0} = head;
   always_ff @(posedge clk)
      if (push)
         mem[wr_ptr] <= {ts, output_1_aktv, output_0_aktv,
                         output_1_aktv ? output_1 : '0, output_0_aktv ? output_0 : '0};
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         ts       <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         cnt      <= '0;
         overflow <= 1'b0;
      end else begin
         if (en) ts <= ts + TS_W'(1);
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         cnt      <= cnt + (AW+1)'(push) - (AW+1)'(pop);
         overflow <= drop | (overflow & !ovf_clr);
      end
`ifdef COLLECTOR_DROP_CNT_EN
   // a drop in the same cycle as a clear restarts the count at one
   always_ff @(posedge clk or posedge rst)
      if (rst) dropped_cnt <= '0;
      else if (drop) dropped_cnt <= ovf_clr ? 16'd1 : dropped_cnt + 16'(dropped_cnt != 16'hFFFF);
      else if (ovf_clr) dropped_cnt <= '0;
`else
   assign dropped_cnt = '0;
`endif
endmodule

// File: tb/tb_rtlola_verdict_collector.sv
// tb_rtlola_verdict_collector: directed table, corner sequences and random traffic against a queue model.
module tb_rtlola_verdict_collector;
   localparam int DW = 64, TW = 32, D = 16;
   logic clk = 1'b0, rst = 1'b1, en = 1'b0, a0 = 1'b0, a1 = 1'b0, ovf_clr = 1'b0, overflow;
   logic signed [DW-1:0] o0 = '0, o1 = '0;
   logic [15:0] dropped_cnt;
   rtlola_verdict_collector_if #(.DATA_W(DW), .TS_W(TW)) rif ();
   rtlola_verdict_collector #(.DATA_W(DW), .TS_W(TW), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .en(en),
      .output_0(o0), .output_0_aktv(a0), .output_1(o1), .output_1_aktv(a1),
      .rec(rif.master), .overflow(overflow), .ovf_clr(ovf_clr), .dropped_cnt(dropped_cnt));
   always #5 clk = ~clk;

   typedef struct {logic [TW-1:0] ts; logic [1:0] mask; logic [DW-1:0] d0, d1;} rec_t;
   typedef struct {
      logic en, a0, a1, rdy;
      logic signed [DW-1:0] d0, d1;
      logic ev; logic [TW-1:0] ets; logic [1:0] em; logic signed [DW-1:0] ed0, ed1;
   } vec_t;
   rec_t q[$];
   logic [TW-1:0] m_ts;
   bit m_ovf;
   int m_dc, n_cmp = 0, n_bad = 0;
   vec_t tbl[7];
   logic [TW-1:0] ts_hold;

   task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int exp_dc();
`ifdef COLLECTOR_DROP_CNT_EN
      return m_dc;
`else
      return 0;
`endif
   endfunction

   task automatic check_model();
      rec_t h;
      h.ts = '0; h.mask = '0; h.d0 = '0; h.d1 = '0;
      if (q.size() > 0) h = q[0];
      chk("rec_valid", DW'(rif.rec_valid), DW'(q.size() > 0));
      chk("rec_ts", DW'(rif.rec_ts), DW'(h.ts));
      chk("rec_mask", DW'(rif.rec_mask), DW'(h.mask));
      chk("rec_data_0", rif.rec_data_0, h.d0);
      chk("rec_data_1", rif.rec_data_1, h.d1);
      chk("overflow", DW'(overflow), DW'(m_ovf));
      chk("dropped_cnt", DW'(dropped_cnt), DW'(exp_dc()));
   endtask

   task automatic model_reset();
      q.delete();
      m_ts = '0; m_ovf = 0; m_dc = 0;
   endtask

   // advance the model on the pre-edge inputs, clock once, then compare
   task automatic tick();
      bit pop, preq, drop;
      rec_t r;
      pop  = q.size() > 0 && rif.rec_ready;
      preq = en && (a0 || a1);
      drop = preq && q.size() == D && !pop;
      if (pop) void'(q.pop_front());
      if (preq && !drop) begin
         r.ts = m_ts; r.mask = {a1, a0}; r.d0 = a0 ? o0 : '0; r.d1 = a1 ? o1 : '0;
         q.push_back(r);
      end
      if (drop) begin
         m_ovf = 1;
         m_dc = ovf_clr ? 1 : (m_dc < 65535 ? m_dc + 1 : m_dc);
      end else if (ovf_clr) begin
         m_ovf = 0; m_dc = 0;
      end
      if (en) m_ts = m_ts + 1;
      @(posedge clk); #1;
      check_model();
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 0; a0 = 0; a1 = 0; ovf_clr = 0; rif.rec_ready = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      check_model();
   endtask

   initial begin
      rif.rec_ready = 1'b0;
      tbl[0] = '{1, 1, 0, 0, -5, 77,  1, 0, 2'b01, -5, 0};
      tbl[1] = '{1, 0, 1, 0, 3, -9,   1, 0, 2'b01, -5, 0};
      tbl[2] = '{0, 1, 1, 1, 8, 8,    1, 1, 2'b10, 0, -9};
      tbl[3] = '{0, 1, 0, 1, 8, 8,    0, 0, 2'b00, 0, 0};
      tbl[4] = '{1, 1, 1, 1, 100, 200, 1, 2, 2'b11, 100, 200};
      tbl[5] = '{1, 0, 0, 0, 1, 1,    1, 2, 2'b11, 100, 200};
      tbl[6] = '{1, 0, 0, 1, 1, 1,    0, 0, 2'b00, 0, 0};
      do_reset();
      for (int i = 0; i < 7; i++) begin
         en = tbl[i].en; a0 = tbl[i].a0; a1 = tbl[i].a1; rif.rec_ready = tbl[i].rdy;
         o0 = tbl[i].d0; o1 = tbl[i].d1;
         tick();
         chk($sformatf("tbl%0d_valid", i), DW'(rif.rec_valid), DW'(tbl[i].ev));
         chk($sformatf("tbl%0d_ts", i), DW'(rif.rec_ts), DW'(tbl[i].ets));
         chk($sformatf("tbl%0d_mask", i), DW'(rif.rec_mask), DW'(tbl[i].em));
         chk($sformatf("tbl%0d_d0", i), rif.rec_data_0, tbl[i].ed0);
         chk($sformatf("tbl%0d_d1", i), rif.rec_data_1, tbl[i].ed1);
      end
      // first capture lands on ts=999 after a long enabled idle stretch
      do_reset();
      en = 1; a0 = 0; a1 = 0; rif.rec_ready = 0;
      for (int i = 0; i < 999; i++) tick();
      chk("t1_idle_valid", DW'(rif.rec_valid), '0);
      a0 = 1; a1 = 1; o0 = 1; o1 = 1;
      tick();
      a0 = 0; a1 = 0;
      chk("t1_ts", DW'(rif.rec_ts), 999);
      chk("t1_mask", DW'(rif.rec_mask), 3);
      chk("t1_d0", rif.rec_data_0, 1);
      chk("t1_d1", rif.rec_data_1, 1);
      rif.rec_ready = 1;
      tick();
      // overflow: DEPTH+3 pushes with the host stalled
      rif.rec_ready = 0; a0 = 1;
      for (int i = 0; i < D + 3; i++) begin o0 = i; tick(); end
      a0 = 0;
      chk("t3_ovf", DW'(overflow), 1);
`ifdef COLLECTOR_DROP_CNT_EN
      chk("t3_dropped", DW'(dropped_cnt), 3);
`endif
      chk("t3_head", rif.rec_data_0, 0);
      ovf_clr = 1; tick(); ovf_clr = 0;
      chk("t3_clr_ovf", DW'(overflow), 0);
      chk("t3_clr_dropped", DW'(dropped_cnt), 0);
      // full FIFO, push and pop together
      a0 = 1; o0 = 100; rif.rec_ready = 1; tick();
      chk("t4_head", rif.rec_data_0, 1);
      chk("t4_no_drop", DW'(overflow), 0);
      rif.rec_ready = 0; o0 = 200; tick();
      chk("t4_still_full", DW'(overflow), 1);
      tick();
      ovf_clr = 1; tick();
      chk("drop_wins_ovf", DW'(overflow), 1);
`ifdef COLLECTOR_DROP_CNT_EN
      chk("drop_wins_cnt", DW'(dropped_cnt), 1);
`endif
      a0 = 0; tick(); ovf_clr = 0;
      // disabled monitor: no capture, ts frozen, drain continues
      ts_hold = m_ts;
      en = 0; a0 = 1; a1 = 1; rif.rec_ready = 1;
      for (int i = 0; i < 10; i++) tick();
      chk("t5_head", rif.rec_data_0, 11);
      a0 = 0; a1 = 0;
      for (int i = 0; i < 6; i++) tick();
      chk("t5_empty", DW'(rif.rec_valid), 0);
      en = 1; a0 = 1; rif.rec_ready = 0; tick();
      chk("t5_ts", DW'(rif.rec_ts), DW'(ts_hold));
      // asynchronous reset with records queued
      do_reset();
      en = 1; a0 = 1;
      for (int i = 0; i < 5; i++) begin o0 = i + 40; tick(); end
      #2 rst = 1'b1;
      #1 chk("t6_async_valid", DW'(rif.rec_valid), 0);
      chk("t6_async_ts", DW'(rif.rec_ts), 0);
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      a0 = 1; o0 = 7; tick();
      chk("t6_ts0", DW'(rif.rec_ts), 0);
      chk("t6_d0", rif.rec_data_0, 7);
      // random traffic, host throttled hard in the first half to force drops
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         en = $urandom_range(0, 7) != 0;
         a0 = $urandom_range(0, 1) == 1;
         a1 = $urandom_range(0, 2) == 0;
         o0 = {$urandom, $urandom};
         o1 = {$urandom, $urandom};
         rif.rec_ready = i < 1500 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0;
         ovf_clr = $urandom_range(0, 63) == 0;
         tick();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
